// File: rtl/clint_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : clint_bus_arbiter
// Brief    : Round-robin arbiter that shares myclint's single native CPU port
//            between N_MASTERS requesters, one outstanding access at a time.
//            Optional slave watchdog enabled by defining CLINT_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module clint_bus_arbiter #(
    parameter int N_MASTERS      = 2,
    parameter int ADDR_W         = 16,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [N_MASTERS-1:0]            m_valid,
    input  logic [N_MASTERS*ADDR_W-1:0]     m_address,
    input  logic [N_MASTERS*DATA_W-1:0]     m_wdata,
    input  logic [N_MASTERS*(DATA_W/8)-1:0] m_wstrb,
    output logic [DATA_W-1:0]               m_rdata,
    output logic [N_MASTERS-1:0]            m_ready,
    output logic                            s_valid,
    output logic [ADDR_W-1:0]               s_address,
    output logic [DATA_W-1:0]               s_wdata,
    output logic [DATA_W/8-1:0]             s_wstrb,
    input  logic [DATA_W-1:0]               s_rdata,
    input  logic                            s_ready,
    output logic [$clog2(N_MASTERS)-1:0]    grant_id,
    output logic                            timeout_err
);

    localparam int c_GW = $clog2(N_MASTERS);
    localparam int c_SW = DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t                r_state_q, w_state_d;
    logic [c_GW-1:0]       r_grant_q, w_grant_d;
    logic [c_GW-1:0]       r_last_q,  w_last_d;
    logic [ADDR_W-1:0]     r_addr_q,  w_addr_d;
    logic [DATA_W-1:0]     r_wdata_q, w_wdata_d;
    logic [c_SW-1:0]       r_wstrb_q, w_wstrb_d;
    logic [DATA_W-1:0]     r_rdata_q, w_rdata_d;
    logic [N_MASTERS-1:0]  r_ready_q, w_ready_d;

    logic [c_GW-1:0]       w_hi_idx, w_lo_idx, w_pick_idx;
    logic                  w_hi_found;
    logic [ADDR_W-1:0]     w_pick_addr;
    logic [DATA_W-1:0]     w_pick_wdata;
    logic [c_SW-1:0]       w_pick_wstrb;
    logic [N_MASTERS-1:0]  w_grant_onehot;

`ifdef CLINT_ARB_TIMEOUT_EN
    localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

    logic [c_CNT_W-1:0]    r_count_q, w_count_d;
    logic                  r_terr_q,  w_terr_d;
`else
    logic                  w_unused_timeout_cfg;
    assign w_unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    // Lowest requester above last_grant wins; otherwise wrap to lowest requester overall.
    always_comb begin
        w_hi_found = 1'b0;
        w_hi_idx   = '0;
        w_lo_idx   = '0;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_valid[i]) begin
                w_lo_idx = c_GW'(i);
                if (c_GW'(i) > r_last_q) begin
                    w_hi_idx   = c_GW'(i);
                    w_hi_found = 1'b1;
                end
            end
        end
        w_pick_idx = w_hi_found ? w_hi_idx : w_lo_idx;
    end

    always_comb begin
        w_pick_addr    = '0;
        w_pick_wdata   = '0;
        w_pick_wstrb   = '0;
        w_grant_onehot = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (c_GW'(i) == w_pick_idx) begin
                w_pick_addr  = m_address[i*ADDR_W +: ADDR_W];
                w_pick_wdata = m_wdata[i*DATA_W +: DATA_W];
                w_pick_wstrb = m_wstrb[i*c_SW +: c_SW];
            end
            if (c_GW'(i) == r_grant_q) begin
                w_grant_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_grant_d = r_grant_q;
        w_last_d  = r_last_q;
        w_addr_d  = r_addr_q;
        w_wdata_d = r_wdata_q;
        w_wstrb_d = r_wstrb_q;
        w_rdata_d = r_rdata_q;
        w_ready_d = '0;
`ifdef CLINT_ARB_TIMEOUT_EN
        w_count_d = r_count_q;
        w_terr_d  = 1'b0;
`endif
        unique case (r_state_q)
            ST_IDLE: begin
                if (|m_valid) begin
                    w_grant_d = w_pick_idx;
                    w_last_d  = w_pick_idx;
                    w_addr_d  = w_pick_addr;
                    w_wdata_d = w_pick_wdata;
                    w_wstrb_d = w_pick_wstrb;
                    w_state_d = ST_ISSUE;
`ifdef CLINT_ARB_TIMEOUT_EN
                    w_count_d = '0;
`endif
                end
            end
            ST_ISSUE, ST_WAIT: begin
                if (s_ready) begin
                    w_rdata_d = s_rdata;
                    w_ready_d = w_grant_onehot;
                    w_state_d = ST_IDLE;
                end
`ifdef CLINT_ARB_TIMEOUT_EN
                else if (r_count_q == c_CNT_LAST) begin
                    // Watchdog completes the access itself so the master is never stuck.
                    w_rdata_d = '0;
                    w_ready_d = w_grant_onehot;
                    w_terr_d  = 1'b1;
                    w_state_d = ST_IDLE;
                end
`endif
                else begin
                    w_state_d = ST_WAIT;
`ifdef CLINT_ARB_TIMEOUT_EN
                    w_count_d = r_count_q + 1'b1;
`endif
                end
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q <= ST_IDLE;
            r_grant_q <= '0;
            r_last_q  <= c_GW'(N_MASTERS - 1);
            r_addr_q  <= '0;
            r_wdata_q <= '0;
            r_wstrb_q <= '0;
            r_rdata_q <= '0;
            r_ready_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_grant_q <= w_grant_d;
            r_last_q  <= w_last_d;
            r_addr_q  <= w_addr_d;
            r_wdata_q <= w_wdata_d;
            r_wstrb_q <= w_wstrb_d;
            r_rdata_q <= w_rdata_d;
            r_ready_q <= w_ready_d;
        end
    end

`ifdef CLINT_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count_q <= '0;
            r_terr_q  <= 1'b0;
        end else begin
            r_count_q <= w_count_d;
            r_terr_q  <= w_terr_d;
        end
    end

    assign timeout_err = r_terr_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign s_valid   = (r_state_q == ST_ISSUE);
    assign s_wstrb   = (r_state_q == ST_ISSUE) ? r_wstrb_q : '0;
    assign s_address = r_addr_q;
    assign s_wdata   = r_wdata_q;
    assign grant_id  = r_grant_q;
    assign m_ready   = r_ready_q;
    assign m_rdata   = r_rdata_q;

endmodule
`default_nettype wire
